// File: rtl/chip8_alu_sequencer.sv
// Multi-cycle executor for the CHIP-8 8XYN ALU group: reads VX/VY through one read port,
// then writes VX and (optionally) VF through one write port before pulsing done.
module chip8_alu_sequencer #(
  parameter int unsigned VF_RESET_QUIRK = 1,
  parameter int unsigned SHIFT_SRC_VX   = 0
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        op_valid,
  output logic        op_ready,
  input  logic [15:0] opcode,
  output logic [3:0]  reg_raddr,
  input  logic [7:0]  reg_rdata,
  output logic        reg_we,
  output logic [3:0]  reg_waddr,
  output logic [7:0]  reg_wdata,
  output logic        done,
  output logic        illegal
);

  localparam bit QuirkEn = (VF_RESET_QUIRK != 0);
  localparam bit ShiftVx = (SHIFT_SRC_VX != 0);

  typedef enum logic [2:0] {
    StIdle,
    StIllegal,
    StRdX,
    StRdY,
    StExec,
    StWrX,
    StWrF
  } state_e;

  state_e      state_q, state_d;
  logic [3:0]  x_q, y_q, n_q;
  logic [7:0]  vx_q;
  logic [7:0]  result_q, flag_q_byte;
  logic        flag_q;
  logic        legal;
  logic        flag_op;
  logic [7:0]  alu_result;
  logic        alu_flag;
  logic [7:0]  shift_src;
  logic [8:0]  sum;

  assign legal = (opcode[15:12] == 4'h8) && ((opcode[3:0] <= 4'h7) || (opcode[3:0] == 4'hE));

  // Logic ops only touch VF when the reset quirk is enabled; LD never does.
  assign flag_op = (n_q >= 4'h4) || (QuirkEn && (n_q != 4'h0));

  assign flag_q_byte = {7'b0, flag_q};

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:    if (op_valid) state_d = legal ? StRdX : StIllegal;
      StIllegal: state_d = StIdle;
      StRdX:     state_d = StRdY;
      StRdY:     state_d = StExec;
      StExec:    state_d = StWrX;
      StWrX:     state_d = flag_op ? StWrF : StIdle;
      StWrF:     state_d = StIdle;
      default:   state_d = StIdle;
    endcase
  end

  // In StExec reg_rdata carries VY; vx_q was captured one cycle earlier.
  always_comb begin
    sum        = {1'b0, vx_q} + {1'b0, reg_rdata};
    shift_src  = ShiftVx ? vx_q : reg_rdata;
    alu_result = reg_rdata;
    alu_flag   = 1'b0;
    case (n_q)
      4'h1: alu_result = vx_q | reg_rdata;
      4'h2: alu_result = vx_q & reg_rdata;
      4'h3: alu_result = vx_q ^ reg_rdata;
      4'h4: begin
        alu_result = sum[7:0];
        alu_flag   = sum[8];
      end
      4'h5: begin
        alu_result = vx_q - reg_rdata;
        alu_flag   = (vx_q >= reg_rdata);
      end
      4'h7: begin
        alu_result = reg_rdata - vx_q;
        alu_flag   = (reg_rdata >= vx_q);
      end
      4'h6: begin
        alu_result = {1'b0, shift_src[7:1]};
        alu_flag   = shift_src[0];
      end
      4'hE: begin
        alu_result = {shift_src[6:0], 1'b0};
        alu_flag   = shift_src[7];
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= StIdle;
      x_q      <= 4'h0;
      y_q      <= 4'h0;
      n_q      <= 4'h0;
      vx_q     <= 8'h00;
      result_q <= 8'h00;
      flag_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == StIdle && op_valid) begin
        x_q <= opcode[11:8];
        y_q <= opcode[7:4];
        n_q <= opcode[3:0];
      end
      if (state_q == StRdY) vx_q <= reg_rdata;
      if (state_q == StExec) begin
        result_q <= alu_result;
        flag_q   <= alu_flag;
      end
    end
  end

  always_comb begin
    op_ready  = (state_q == StIdle);
    reg_raddr = 4'h0;
    reg_we    = 1'b0;
    reg_waddr = 4'h0;
    reg_wdata = 8'h00;
    done      = 1'b0;
    illegal   = 1'b0;
    unique case (state_q)
      StIllegal: illegal = 1'b1;
      StRdX:     reg_raddr = x_q;
      StRdY:     reg_raddr = y_q;
      StWrX: begin
        reg_we    = 1'b1;
        reg_waddr = x_q;
        reg_wdata = result_q;
        done      = !flag_op;
      end
      StWrF: begin
        reg_we    = 1'b1;
        reg_waddr = 4'hF;
        reg_wdata = flag_q_byte;
        done      = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_chip8_alu_sequencer.sv
// Scoreboard bench: two DUTs (quirk on/VY shift, quirk off/VX shift) share one opcode stream,
// each with its own register file; a monitor pops expected writes/pulses as the DUTs emit them.
module tb_chip8_alu_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_n;
  logic        op_valid;
  logic [15:0] opcode;
  logic        op_ready  [2];
  logic [3:0]  reg_raddr [2];
  logic [7:0]  reg_rdata [2];
  logic        reg_we    [2];
  logic [3:0]  reg_waddr [2];
  logic [7:0]  reg_wdata [2];
  logic        done      [2];
  logic        illegal   [2];

  logic        pre_we;
  logic [3:0]  pre_addr;
  logic [7:0]  pre_data;
  logic [7:0]  rf [2][16];
  int          cyc = 0;

  chip8_alu_sequencer #(.VF_RESET_QUIRK(1), .SHIFT_SRC_VX(0)) dut0 (
    .clk(clk), .reset_n(reset_n), .op_valid(op_valid), .op_ready(op_ready[0]),
    .opcode(opcode), .reg_raddr(reg_raddr[0]), .reg_rdata(reg_rdata[0]), .reg_we(reg_we[0]),
    .reg_waddr(reg_waddr[0]), .reg_wdata(reg_wdata[0]), .done(done[0]), .illegal(illegal[0])
  );

  chip8_alu_sequencer #(.VF_RESET_QUIRK(0), .SHIFT_SRC_VX(1)) dut1 (
    .clk(clk), .reset_n(reset_n), .op_valid(op_valid), .op_ready(op_ready[1]),
    .opcode(opcode), .reg_raddr(reg_raddr[1]), .reg_rdata(reg_rdata[1]), .reg_we(reg_we[1]),
    .reg_waddr(reg_waddr[1]), .reg_wdata(reg_wdata[1]), .done(done[1]), .illegal(illegal[1])
  );

  always @(posedge clk) begin
    cyc <= cyc + 1;
    for (int d = 0; d < 2; d++) begin
      reg_rdata[d] <= rf[d][reg_raddr[d]];
      if (pre_we) rf[d][pre_addr] <= pre_data;
      else if (reg_we[d] === 1'b1) rf[d][reg_waddr[d]] <= reg_wdata[d];
    end
  end

  typedef struct {
    bit ill;
    int addr;
    int data;
    bit dn;
    int at;
  } ev_t;

  ev_t exp_q0[$];
  ev_t exp_q1[$];
  int  mrf [2][16];
  int  checks = 0;
  int  passes = 0;

  task automatic check(input bit ok, input string name, input int got, input int exp);
    checks++;
    if (ok) passes++;
    else $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, got, got, exp, exp);
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic push(input int d, input bit ill, input int addr, input int data, input bit dn,
                      input int at);
    ev_t e;
    e.ill = ill; e.addr = addr; e.data = data; e.dn = dn; e.at = at;
    if (d == 0) exp_q0.push_back(e);
    else exp_q1.push_back(e);
  endtask

  // Reference: computes CHIP-8 8XYN semantics on the model register file.
  task automatic model(input logic [15:0] op, input int t, output int rdy0, output int rdy1);
    for (int d = 0; d < 2; d++) begin
      int x, y, n, vx, vy, s, r, f, rdy;
      bit wf, quirk, shvx;
      x = int'(op[11:8]); y = int'(op[7:4]); n = int'(op[3:0]);
      vx = mrf[d][x]; vy = mrf[d][y];
      quirk = (d == 0); shvx = (d == 1);
      s = 0; r = 0; f = 0; wf = 1'b1;
      if (op[15:12] != 4'h8 || (n > 7 && n != 14)) begin
        push(d, 1'b1, 0, 0, 1'b0, t + 1);
        rdy = t + 2;
      end else begin
        case (n)
          0: begin r = vy; wf = 1'b0; end
          1: begin r = vx | vy; wf = quirk; end
          2: begin r = vx & vy; wf = quirk; end
          3: begin r = vx ^ vy; wf = quirk; end
          4: begin s = vx + vy; r = s % 256; f = s / 256; end
          5: begin r = (vx - vy + 256) % 256; f = (vx >= vy) ? 1 : 0; end
          7: begin r = (vy - vx + 256) % 256; f = (vy >= vx) ? 1 : 0; end
          6: begin s = shvx ? vx : vy; r = s / 2; f = s % 2; end
          default: begin s = shvx ? vx : vy; r = (s * 2) % 256; f = s / 128; end
        endcase
        push(d, 1'b0, x, r, !wf, t + 4);
        mrf[d][x] = r;
        if (wf) begin
          push(d, 1'b0, 15, f, 1'b1, t + 5);
          mrf[d][15] = f;
        end
        rdy = wf ? t + 6 : t + 5;
      end
      if (d == 0) rdy0 = rdy;
      else rdy1 = rdy;
    end
  endtask

  task automatic monitor();
    forever begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        if (reg_we[d] === 1'b1 || done[d] === 1'b1 || illegal[d] === 1'b1) begin
          ev_t e;
          bit have, ok;
          have = (d == 0) ? (exp_q0.size() > 0) : (exp_q1.size() > 0);
          checks++;
          if (!have) begin
            $display("FAIL unexpected_output dut%0d: we=%0b addr=%h data=%h done=%0b ill=%0b cyc=%0d",
                     d, reg_we[d], reg_waddr[d], reg_wdata[d], done[d], illegal[d], cyc);
          end else begin
            e = (d == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
            ok = (illegal[d] == e.ill) && (reg_we[d] == !e.ill) && (done[d] == e.dn) &&
                 (cyc == e.at) &&
                 (e.ill || (int'(reg_waddr[d]) == e.addr && int'(reg_wdata[d]) == e.data));
            if (ok) passes++;
            else $display({"FAIL event dut%0d: got we=%0b ill=%0b addr=%h data=%h done=%0b cyc=%0d,",
                           " expected ill=%0b addr=%h data=%h done=%0b cyc=%0d"},
                          d, reg_we[d], illegal[d], reg_waddr[d], reg_wdata[d], done[d], cyc,
                          e.ill, e.addr, e.data, e.dn, e.at);
          end
        end
      end
    end
  endtask

  task automatic set_reg(input int a, input int v);
    pre_we = 1'b1; pre_addr = 4'(a); pre_data = 8'(v);
    step();
    pre_we = 1'b0;
    mrf[0][a] = v; mrf[1][a] = v;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 20 && !(op_ready[0] && op_ready[1]); i++) step();
  endtask

  task automatic issue_start(input logic [15:0] op, output int t0, output int r0, output int r1);
    wait_idle();
    opcode = op; op_valid = 1'b1; t0 = cyc;
    model(op, t0, r0, r1);
    step();
    op_valid = 1'b0;
    opcode = 16'($urandom);
  endtask

  task automatic wait_ready(input int r0, input int r1);
    int g0, g1;
    g0 = -1; g1 = -1;
    for (int i = 0; i < 20 && (g0 < 0 || g1 < 0); i++) begin
      step();
      if (op_ready[0] && g0 < 0) g0 = cyc;
      if (op_ready[1] && g1 < 0) g1 = cyc;
    end
    check(g0 == r0, "ready_cycle_dut0", g0, r0);
    check(g1 == r1, "ready_cycle_dut1", g1, r1);
    check(exp_q0.size() == 0, "missing_events_dut0", exp_q0.size(), 0);
    check(exp_q1.size() == 0, "missing_events_dut1", exp_q1.size(), 0);
  endtask

  task automatic run_op(input logic [15:0] op);
    int t0, r0, r1;
    issue_start(op, t0, r0, r1);
    wait_ready(r0, r1);
  endtask

  initial begin
    int t0, r0, r1, t2, q0, q1, sv3 [2], svf [2];
    logic [15:0] op;
    int ns [9];
    ns = '{0, 1, 2, 3, 4, 5, 6, 7, 14};
    fork
      monitor();
    join_none

    reset_n = 1'b1; op_valid = 1'b0; opcode = 16'h0; pre_we = 1'b0;
    pre_addr = 4'h0; pre_data = 8'h0;
    #1 reset_n = 1'b0;
    step(); step();
    for (int d = 0; d < 2; d++) begin
      check(op_ready[d] == 1'b1, "reset_op_ready", int'(op_ready[d]), 1);
      check(reg_we[d] == 1'b0, "reset_reg_we", int'(reg_we[d]), 0);
      check(done[d] == 1'b0 && illegal[d] == 1'b0, "reset_pulses",
            int'({done[d], illegal[d]}), 0);
      check(reg_raddr[d] == 4'h0, "reset_raddr", int'(reg_raddr[d]), 0);
    end
    reset_n = 1'b1;
    step();
    for (int a = 0; a < 16; a++) set_reg(a, int'($urandom_range(0, 255)));

    // Directed cases
    set_reg(3, 'hF0); set_reg(5, 'h20); run_op(16'h8354);
    set_reg(1, 'h10); set_reg(2, 'h20); run_op(16'h8125);
    set_reg(1, 'h20); set_reg(2, 'h20); run_op(16'h8125);
    set_reg(4, 'h00); set_reg(6, 'h81); run_op(16'h846E);
    set_reg(15, 'h0F); set_reg(0, 'h01); run_op(16'h8F04);
    run_op(16'h8AB1);
    run_op(16'h8128);
    run_op(16'h7128);
    run_op(16'h8333);

    // Back-to-back LDs with op_valid held
    wait_idle();
    opcode = 16'h8120; op_valid = 1'b1; t0 = cyc;
    model(16'h8120, t0, r0, r1);
    step();
    opcode = 16'h8340;
    for (int i = 0; i < 20 && !(op_ready[0] && op_ready[1]); i++) step();
    t2 = cyc;
    check(t2 == r0, "back_to_back_accept", t2, r0);
    model(16'h8340, r0, q0, q1);
    step();
    op_valid = 1'b0;
    wait_ready(q0, q1);

    // Reset during WR_X
    set_reg(3, 'hF0); set_reg(5, 'h20);
    for (int d = 0; d < 2; d++) begin sv3[d] = mrf[d][3]; svf[d] = mrf[d][15]; end
    issue_start(16'h8354, t0, r0, r1);
    for (int i = 0; i < 10 && reg_we[0] !== 1'b1; i++) step();
    check(reg_we[0] === 1'b1, "reach_wr_x", int'(reg_we[0]), 1);
    reset_n = 1'b0;
    #1;
    for (int d = 0; d < 2; d++) begin
      check(reg_we[d] == 1'b0, "async_reset_we", int'(reg_we[d]), 0);
      mrf[d][3] = sv3[d]; mrf[d][15] = svf[d];
    end
    exp_q0.delete(); exp_q1.delete();
    step(); step();
    reset_n = 1'b1;
    step();
    for (int d = 0; d < 2; d++) begin
      check(op_ready[d] == 1'b1, "post_reset_ready", int'(op_ready[d]), 1);
      check(done[d] == 1'b0 && illegal[d] == 1'b0, "post_reset_pulses",
            int'({done[d], illegal[d]}), 0);
    end

    // Randomized ops
    for (int k = 0; k < 80; k++) begin
      if ($urandom_range(0, 3) == 0) set_reg(int'($urandom_range(0, 15)), int'($urandom_range(0, 255)));
      op = {4'h8, 4'($urandom), 4'($urandom), 4'(ns[$urandom_range(0, 8)])};
      if ($urandom_range(0, 9) == 0) op = 16'($urandom);
      run_op(op);
    end

    wait_idle();
    step();
    for (int d = 0; d < 2; d++)
      for (int a = 0; a < 16; a++)
        check(int'(rf[d][a]) == mrf[d][a], "final_regfile", int'(rf[d][a]), mrf[d][a]);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
